snake_draw_scheduler: RTL and testbench
=======================================

# snake_draw_scheduler

Sequences and arbitrates all pixel writes to the VGA adapter write port for the snake game. After each game step the snake logic raises requests for tail erase, head draw and food draw. This block grants them one at a time and rasterises each 4x4 cell into single-pixel writes. It also performs a full-screen background clear after reset or on request. It sits between the snake game FSM and the VGA adapter inside the game core, clocked by the 50 MHz board clock.

## Interface
Parameters:
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- BG_COLOR, 9'b000_000_000, 3:3:3 background colour used by clear and erase

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- clear_req  in  1  request full-screen clear (pulse or level)
- erase_req  in  1  request tail-cell erase; held until erase_ack
- erase_x / erase_y  in  8 / 7  erase cell pixel origin
- head_req  in  1  request head-cell draw; held until head_ack
- head_x / head_y  in  8 / 7  head cell origin
- head_color  in  9  head colour (3:3:3, from SW[8:0] path)
- food_req  in  1  request food-cell draw; held until food_ack
- food_x / food_y  in  8 / 7  food cell origin
- food_color  in  9  food colour
- erase_ack, head_ack, food_ack  out  1  one-cycle grant pulse; coordinates/colour latched on that edge
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse after each operation's last pixel
- VGA_X  out  8  pixel x to adapter
- VGA_Y  out  7  pixel y to adapter
- VGA_COLOR  out  9  pixel colour
- plot  out  1  adapter write enable

## Operation
- States: IDLE, CLEAR, CELL, FIN.
- Reset (async, immediate): state IDLE, clear_pending=1. All outputs 0: plot, VGA_X, VGA_Y, VGA_COLOR, acks, done, busy. Counters are 0.
- clear_req sets clear_pending on any edge, in any state. clear_pending is cleared when CLEAR is entered.
- IDLE grant priority: clear_pending > erase > head > food. Only one grant per edge. Unserviced requesters keep req high.
- Request latching:
  - erase: latch erase_x/erase_y with colour BG_COLOR.
  - head/food: latch x, y and colour.
  - x[1:0] and y[1:0] are forced to 0, so cells are 4-pixel aligned.
- CELL: a 4-bit counter i steps 0..15. Pixel i is at VGA_X = bx + i[1:0], VGA_Y = by + i[3:2] (row-major). Sums are 8/7 bits with no wrap; wrap-around is the snake logic's responsibility.
- Clipping: any pixel with x ≥ SCR_W or y ≥ SCR_H has plot=0. Its timing slot is still consumed.
- CLEAR: raster x 0..SCR_W-1 inner, y 0..SCR_H-1 outer, colour BG_COLOR. This is 19200 pixels.
- FIN: done=1 for one cycle, then IDLE.
- A requester dropping req before its ack is ignored; no partial state results.
- Outputs are all registered. VGA_X, VGA_Y and VGA_COLOR hold their last value while plot=0.

## Timing
- CELL operation, with the grant at edge k (state IDLE, req high):
  - edge k: ack=1 for one cycle; state=CELL; plot=0.
  - edges k+1..k+16: pixel i=0..15 presented with plot=1.
  - edge k+17: plot=0, done=1, state FIN.
  - edge k+18: state IDLE. The next grant is possible at edge k+18.
- A cell operation therefore costs 18 cycles and 16 writes.
- CLEAR operation: same structure, with plot at edges k+1..k+19200 and done at edge k+19201. There is no ack for clear.
- First clear after reset: grant on the first edge after resetn deasserts. The first pixel (0,0) follows one edge later.
- Reset mid-operation: plot drops asynchronously to 0 and the operation is abandoned. After resetn rises, a full clear restarts; any un-acked requests are serviced after it.
- Simultaneous erase+head+food in IDLE: acks at edges k, k+18 and k+36, in the order erase, head, food.
- clear_req during CELL: the current cell completes, then CLEAR is granted at the next IDLE, ahead of waiting cell requests.

## Test plan
- Reset release -> 19200 plots, all colour 0. First pixel (0,0), pixel 160 is (0,1), last (159,119). done pulses once at edge 19201. No acks.
- head_req=1, head=(8,12), colour 9'b000_111_000 -> one head_ack pulse; 16 plots covering x 8..11, y 12..15 in row-major order; done 17 cycles after the ack.
- erase_req, head_req and food_req raised on the same cycle -> acks in order erase, head, food, 18 cycles apart. Erase pixels use colour 0; busy stays high except the single IDLE cycles between operations.
- head=(160,0) -> ack and done occur; 16 slots with plot=0 throughout. head=(157,118) is aligned to (156,116) -> 16 plots with x 156..159, y 116..119.
- resetn pulled low at the 6th pixel of a head cell -> plot goes to 0 within the reset cycle and no done pulse occurs. After release, a full 19200-pixel clear runs before the still-held head_req is acked.
- clear_req pulsed during a food cell -> food finishes all 16 plots, then CLEAR runs ahead of a pending erase_req, then erase_ack follows.

Source files
------------

// File: rtl/snake_draw_scheduler.sv
// Pixel-write scheduler for the snake game: arbitrates clear/erase/head/food
// requests and rasterises each into single-pixel writes for the VGA adapter.
module snake_draw_scheduler #(
   parameter int         SCR_W    = 160,
   parameter int         SCR_H    = 120,
   parameter logic [8:0] BG_COLOR = 9'b000_000_000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       clear_req,
   input  logic       erase_req,
   input  logic [7:0] erase_x,
   input  logic [6:0] erase_y,
   input  logic       head_req,
   input  logic [7:0] head_x,
   input  logic [6:0] head_y,
   input  logic [8:0] head_color,
   input  logic       food_req,
   input  logic [7:0] food_x,
   input  logic [6:0] food_y,
   input  logic [8:0] food_color,
   output logic       erase_ack,
   output logic       head_ack,
   output logic       food_ack,
   output logic       busy,
   output logic       done,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [8:0] VGA_COLOR,
   output logic       plot
);

   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, CELL = 2'd2, FIN = 2'd3} state_t;

   localparam logic [7:0] LP_X_LAST = 8'(SCR_W - 1);
   localparam logic [6:0] LP_Y_LAST = 7'(SCR_H - 1);

   state_t     r_state;
   state_t     w_next_state;
   logic       r_clear_pending;
   logic [7:0] r_bx;
   logic [6:0] r_by;
   logic [8:0] r_color;
   logic [3:0] r_i;
   logic [7:0] r_cx;
   logic [6:0] r_cy;

   logic       w_grant_clear, w_grant_erase, w_grant_head, w_grant_food;
   logic       w_pix_en, w_done, w_in_screen;
   logic [7:0] w_px_x;
   logic [6:0] w_px_y;
   logic [8:0] w_px_color;

   // Next-state selection and fixed-priority grant in IDLE.
   always_comb begin
      w_next_state  = r_state;
      w_grant_clear = 1'b0;
      w_grant_erase = 1'b0;
      w_grant_head  = 1'b0;
      w_grant_food  = 1'b0;
      w_pix_en      = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_clear_pending) begin
               w_next_state  = CLEAR;
               w_grant_clear = 1'b1;
            end else if (erase_req) begin
               w_next_state  = CELL;
               w_grant_erase = 1'b1;
            end else if (head_req) begin
               w_next_state  = CELL;
               w_grant_head  = 1'b1;
            end else if (food_req) begin
               w_next_state  = CELL;
               w_grant_food  = 1'b1;
            end else begin
               w_next_state  = IDLE;
            end
         end
         CLEAR: begin
            w_pix_en = 1'b1;
            if ((r_cx == LP_X_LAST) && (r_cy == LP_Y_LAST)) begin
               w_next_state = FIN;
            end else begin
               w_next_state = CLEAR;
            end
         end
         CELL: begin
            w_pix_en = 1'b1;
            if (r_i == 4'd15) begin
               w_next_state = FIN;
            end else begin
               w_next_state = CELL;
            end
         end
         FIN: begin
            w_done       = 1'b1;
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Current pixel address/colour and its on-screen test (off-screen slots still take a cycle).
   always_comb begin
      w_px_x     = 8'd0;
      w_px_y     = 7'd0;
      w_px_color = BG_COLOR;
      if (r_state == CLEAR) begin
         w_px_x     = r_cx;
         w_px_y     = r_cy;
         w_px_color = BG_COLOR;
      end else begin
         w_px_x     = r_bx + {6'd0, r_i[1:0]};
         w_px_y     = r_by + {5'd0, r_i[3:2]};
         w_px_color = r_color;
      end
      w_in_screen = ({24'd0, w_px_x} < 32'(SCR_W)) && ({25'd0, w_px_y} < 32'(SCR_H));
   end

   // State, counters, latched request and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state         <= IDLE;
         r_clear_pending <= 1'b1;
         r_bx            <= 8'd0;
         r_by            <= 7'd0;
         r_color         <= 9'd0;
         r_i             <= 4'd0;
         r_cx            <= 8'd0;
         r_cy            <= 7'd0;
         erase_ack       <= 1'b0;
         head_ack        <= 1'b0;
         food_ack        <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         VGA_X           <= 8'd0;
         VGA_Y           <= 7'd0;
         VGA_COLOR       <= 9'd0;
         plot            <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         // A request on the entry edge itself is kept so it is not lost.
         r_clear_pending <= clear_req | (r_clear_pending & ~w_grant_clear);
         erase_ack       <= w_grant_erase;
         head_ack        <= w_grant_head;
         food_ack        <= w_grant_food;
         busy            <= (w_next_state != IDLE);
         done            <= w_done;

         if (w_pix_en && w_in_screen) begin
            VGA_X     <= w_px_x;
            VGA_Y     <= w_px_y;
            VGA_COLOR <= w_px_color;
            plot      <= 1'b1;
         end else begin
            plot      <= 1'b0;
         end

         if (w_grant_clear) begin
            r_cx <= 8'd0;
            r_cy <= 7'd0;
         end else if (r_state == CLEAR) begin
            if (r_cx == LP_X_LAST) begin
               r_cx <= 8'd0;
               r_cy <= r_cy + 7'd1;
            end else begin
               r_cx <= r_cx + 8'd1;
            end
         end

         if (w_grant_erase) begin
            r_bx    <= {erase_x[7:2], 2'b00};
            r_by    <= {erase_y[6:2], 2'b00};
            r_color <= BG_COLOR;
            r_i     <= 4'd0;
         end else if (w_grant_head) begin
            r_bx    <= {head_x[7:2], 2'b00};
            r_by    <= {head_y[6:2], 2'b00};
            r_color <= head_color;
            r_i     <= 4'd0;
         end else if (w_grant_food) begin
            r_bx    <= {food_x[7:2], 2'b00};
            r_by    <= {food_y[6:2], 2'b00};
            r_color <= food_color;
            r_i     <= 4'd0;
         end else if (r_state == CELL) begin
            r_i     <= r_i + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_snake_draw_scheduler.sv
// Scoreboard bench for snake_draw_scheduler: expected pixels/acks are queued by a
// cell/screen model when stimulus is issued and popped by a negedge monitor.
module tb_snake_draw_scheduler;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       clear_req = 1'b0;
   logic       erase_req = 1'b0, head_req = 1'b0, food_req = 1'b0;
   logic [7:0] erase_x = 8'd0, head_x = 8'd0, food_x = 8'd0;
   logic [6:0] erase_y = 7'd0, head_y = 7'd0, food_y = 7'd0;
   logic [8:0] head_color = 9'd0, food_color = 9'd0;
   logic       erase_ack, head_ack, food_ack, busy, done, plot;
   logic [7:0] VGA_X;
   logic [6:0] VGA_Y;
   logic [8:0] VGA_COLOR;

   snake_draw_scheduler dut (
      .CLOCK_50(clk), .resetn(resetn), .clear_req(clear_req),
      .erase_req(erase_req), .erase_x(erase_x), .erase_y(erase_y),
      .head_req(head_req), .head_x(head_x), .head_y(head_y), .head_color(head_color),
      .food_req(food_req), .food_x(food_x), .food_y(food_y), .food_color(food_color),
      .erase_ack(erase_ack), .head_ack(head_ack), .food_ack(food_ack),
      .busy(busy), .done(done), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
      .VGA_COLOR(VGA_COLOR), .plot(plot)
   );

   always #10 clk = ~clk;

   typedef struct packed {logic [7:0] x; logic [6:0] y; logic [8:0] c;} pix_t;

   pix_t pix_q[$];
   int   ack_q[$];
   int   n_tests = 0, n_fail = 0;
   int   cyc = 0, n_done = 0, n_plot = 0, done_cyc = 0, last_ack_cyc = -1;
   int   ack_cyc[3];

   always @(posedge clk) cyc++;

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endfunction

   // Model: a cell is the aligned 4x4 block, row-major, minus off-screen pixels.
   function automatic void push_cell(int bx, int by, logic [8:0] c);
      int ax, ay;
      ax = bx - (bx % 4);
      ay = by - (by % 4);
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++)
            if ((ax + k) < 160 && (ay + r) < 120)
               pix_q.push_back({8'(ax + k), 7'(ay + r), c});
   endfunction

   function automatic void push_clear();
      for (int y = 0; y < 120; y++)
         for (int x = 0; x < 160; x++)
            pix_q.push_back({8'(x), 7'(y), 9'd0});
   endfunction

   // Monitor: compares every plot and ack against the queues, times ack-to-done.
   always @(negedge clk) begin
      if (resetn) begin
         if (plot) begin
            n_plot++;
            if (pix_q.size() == 0) begin
               check("unexpected_plot", {8'd0, VGA_X, VGA_Y, VGA_COLOR}, -1);
            end else begin
               pix_t e;
               e = pix_q.pop_front();
               check("pixel", {8'd0, VGA_X, VGA_Y, VGA_COLOR}, {8'd0, e});
            end
         end
         if (erase_ack || head_ack || food_ack) begin
            int code;
            code = erase_ack ? 0 : (head_ack ? 1 : 2);
            check("single_ack", int'(erase_ack) + int'(head_ack) + int'(food_ack), 1);
            if (ack_q.size() == 0) check("unexpected_ack", code, -1);
            else check("ack_order", code, ack_q.pop_front());
            ack_cyc[code] = cyc;
            last_ack_cyc  = cyc;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            if (last_ack_cyc >= 0) check("ack_to_done", cyc - last_ack_cyc, 17);
            last_ack_cyc = -1;
         end
      end
   end

   task automatic run(input int budget);
      int n;
      bit fin;
      n = 0;
      fin = 1'b0;
      while (!fin && n < budget) begin
         @(posedge clk); #1; n++;
         if (erase_ack) erase_req = 1'b0;
         if (head_ack)  head_req  = 1'b0;
         if (food_ack)  food_req  = 1'b0;
         if (!busy && !done && !erase_req && !head_req && !food_req &&
             pix_q.size() == 0 && ack_q.size() == 0) fin = 1'b1;
      end
      check("run_completes", int'(fin), 1);
   endtask

   task automatic wait_ack(input int which, output int k);
      int n;
      n = 0;
      k = -1;
      while (k < 0 && n < 60) begin
         @(posedge clk); #1; n++;
         if ((which == 0 && erase_ack) || (which == 1 && head_ack) || (which == 2 && food_ack))
            k = cyc;
      end
      check("ack_seen", int'(k >= 0), 1);
   endtask

   initial begin
      int rel, nd, np, k, mask;

      // Reset state and first full-screen clear.
      #2 resetn = 1'b0;
      #1 check("reset_outputs", {plot, busy, done, erase_ack, head_ack, food_ack,
                                 VGA_X, VGA_Y, VGA_COLOR}, 0);
      repeat (2) @(negedge clk);
      push_clear();
      resetn = 1'b1;
      rel = cyc;
      run(20000);
      check("clear_done_time", done_cyc - (rel + 1), 19201);
      check("clear_done_count", n_done, 1);
      check("clear_plot_count", n_plot, 19200);

      // Directed head draw.
      head_x = 8'd8; head_y = 7'd12; head_color = 9'b000_111_000;
      ack_q.push_back(1); push_cell(8, 12, 9'b000_111_000);
      head_req = 1'b1;
      run(100);

      // Simultaneous erase/head/food.
      erase_x = 8'd40; erase_y = 7'd44;
      head_x = 8'd44; head_y = 7'd44; head_color = 9'h1C7;
      food_x = 8'd100; food_y = 7'd80; food_color = 9'h1FF;
      ack_q.push_back(0); push_cell(40, 44, 9'd0);
      ack_q.push_back(1); push_cell(44, 44, 9'h1C7);
      ack_q.push_back(2); push_cell(100, 80, 9'h1FF);
      nd = n_done;
      erase_req = 1'b1; head_req = 1'b1; food_req = 1'b1;
      run(200);
      check("gap_erase_head", ack_cyc[1] - ack_cyc[0], 18);
      check("gap_head_food", ack_cyc[2] - ack_cyc[1], 18);
      check("triple_done_count", n_done - nd, 3);

      // Clipping boundaries.
      np = n_plot;
      head_x = 8'd160; head_y = 7'd0; head_color = 9'h0AA;
      ack_q.push_back(1);
      head_req = 1'b1;
      run(100);
      check("clip_no_plots", n_plot - np, 0);
      head_x = 8'd157; head_y = 7'd118; head_color = 9'h155;
      ack_q.push_back(1); push_cell(157, 118, 9'h155);
      head_req = 1'b1;
      run(100);
      check("edge_cell_plots", n_plot - np, 16);

      // Randomised request mixes.
      for (int t = 0; t < 25; t++) begin
         mask = $urandom_range(1, 7);
         erase_x = 8'($urandom); erase_y = 7'($urandom);
         head_x = 8'($urandom);  head_y = 7'($urandom);  head_color = 9'($urandom);
         food_x = 8'($urandom);  food_y = 7'($urandom);  food_color = 9'($urandom);
         if (mask[0]) begin ack_q.push_back(0); push_cell(int'(erase_x), int'(erase_y), 9'd0); end
         if (mask[1]) begin ack_q.push_back(1); push_cell(int'(head_x), int'(head_y), head_color); end
         if (mask[2]) begin ack_q.push_back(2); push_cell(int'(food_x), int'(food_y), food_color); end
         erase_req = mask[0]; head_req = mask[1]; food_req = mask[2];
         run(200);
      end

      // clear_req during a food cell: food completes, clear precedes a waiting erase.
      food_x = 8'd20; food_y = 7'd30; food_color = 9'h0F0;
      ack_q.push_back(2); push_cell(20, 30, 9'h0F0);
      food_req = 1'b1;
      wait_ack(2, k);
      food_req = 1'b0;
      repeat (4) @(posedge clk);
      #1 clear_req = 1'b1;
      push_clear();
      erase_x = 8'd20; erase_y = 7'd30;
      ack_q.push_back(0); push_cell(20, 30, 9'd0);
      @(posedge clk); #1 clear_req = 1'b0;
      erase_req = 1'b1;
      run(20000);
      check("erase_after_clear", int'(ack_cyc[0] > ack_cyc[2] + 19200), 1);

      // Reset in the middle of a head cell, with head_req still held.
      head_x = 8'd60; head_y = 7'd60; head_color = 9'h1AB;
      ack_q.push_back(1); push_cell(60, 60, 9'h1AB);
      head_req = 1'b1;
      wait_ack(1, k);
      repeat (6) @(posedge clk);
      #1 resetn = 1'b0;
      nd = n_done;
      #1 check("reset_mid_plot", int'(plot), 0);
      check("reset_mid_done", int'(done), 0);
      pix_q.delete();
      ack_q.delete();
      last_ack_cyc = -1;
      repeat (2) @(negedge clk);
      push_clear();
      ack_q.push_back(1); push_cell(60, 60, 9'h1AB);
      resetn = 1'b1;
      run(20000);
      check("reset_recover_dones", n_done - nd, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
